// File: rtl/cpu_mem_stage_if.sv
// rtl/cpu_mem_stage_if.sv - execute-to-memory-stage bundle and MEM/WB outputs
interface cpu_mem_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             stall;
    logic [WIDTH-1:0] out_alu;
    logic [WIDTH-1:0] rdata2;
    logic             is_write_mem;
    logic             is_read_mem;
    logic [1:0]       mem_size;
    logic             is_unsigned;
    logic [4:0]       rd_in;
    logic             is_write_reg_in;

    logic             out_valid;
    logic [WIDTH-1:0] out_wb;
    logic [WIDTH-1:0] out_memory;
    logic [4:0]       rd_out;
    logic             is_write_reg_out;
    logic             misaligned;

    modport master (
        output in_valid, stall, out_alu, rdata2, is_write_mem, is_read_mem,
               mem_size, is_unsigned, rd_in, is_write_reg_in,
        input  out_valid, out_wb, out_memory, rd_out, is_write_reg_out, misaligned
    );

    modport slave (
        input  in_valid, stall, out_alu, rdata2, is_write_mem, is_read_mem,
               mem_size, is_unsigned, rd_in, is_write_reg_in,
        output out_valid, out_wb, out_memory, rd_out, is_write_reg_out, misaligned
    );
endinterface

// File: rtl/cpu_mem_stage.sv
// rtl/cpu_mem_stage.sv - CPU memory stage: byte-addressable data memory and MEM/WB register
module cpu_mem_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_mem_stage_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][31:0] mem;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             sz_byte;
    logic             sz_half;
    logic             addr_bad;
    logic             active;
    logic             mis;
    logic             is_load;
    logic             store_en;
    logic             load_en;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_ext;
    logic [31:0]      load_data;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [WIDTH-1:0] wb_next;

    // Upper address bits are dropped, so accesses wrap modulo 4*DEPTH bytes.
    assign idx     = bus.out_alu[IDX_W+1:2];
    assign lane    = bus.out_alu[1:0];
    assign sz_byte = (bus.mem_size == 2'b00);
    assign sz_half = (bus.mem_size == 2'b01);

    assign addr_bad = (sz_half & lane[0]) | (~sz_byte & ~sz_half & (lane != 2'b00));
    assign active   = bus.in_valid & ~bus.stall;
    assign mis      = active & (bus.is_write_mem | bus.is_read_mem) & addr_bad;
    assign is_load  = active & bus.is_read_mem & ~bus.is_write_mem;
    assign store_en = active & bus.is_write_mem & ~addr_bad;
    assign load_en  = is_load & ~addr_bad;
    assign rd_word  = mem[idx];

    always_comb begin
        byte_sel = 8'h00;
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

        if (sz_byte) begin
            load_ext = {{24{~bus.is_unsigned & byte_sel[7]}}, byte_sel};
        end else if (sz_half) begin
            load_ext = {{16{~bus.is_unsigned & half_sel[15]}}, half_sel};
        end else begin
            load_ext = rd_word;
        end
    end

    assign load_data = load_en ? load_ext : 32'h0;
    // Misaligned loads still select the load path, so they write back 0.
    assign wb_next   = is_load ? load_data : bus.out_alu;

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = bus.rdata2;
        if (sz_byte) begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{bus.rdata2[7:0]}};
        end else if (sz_half) begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.rdata2[15:0]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid        <= 1'b0;
            bus.out_wb           <= '0;
            bus.out_memory       <= '0;
            bus.rd_out           <= 5'd0;
            bus.is_write_reg_out <= 1'b0;
            bus.misaligned       <= 1'b0;
        end else if (!bus.stall) begin
            bus.out_valid        <= bus.in_valid;
            bus.out_wb           <= bus.in_valid ? wb_next : '0;
            bus.out_memory       <= load_data;
            bus.rd_out           <= bus.rd_in;
            bus.is_write_reg_out <= bus.in_valid & bus.is_write_reg_in & ~mis;
            bus.misaligned       <= mis;
        end
    end
endmodule

// File: tb/tb_cpu_mem_stage.sv
// tb/tb_cpu_mem_stage.sv - scoreboard bench for cpu_mem_stage against a byte-array model
module tb_cpu_mem_stage;
    logic clk;
    logic rst;

    cpu_mem_stage_if #(.WIDTH(32)) bus ();

    cpu_mem_stage #(.WIDTH(32), .DEPTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] wb;
        logic [31:0] memv;
        logic [4:0]  rd;
        logic        wr;
        logic        mis;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       held;
    logic [7:0] bmem [128];
    int         checks = 0;
    int         fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) bmem[i] = 8'h00;
        held = '{1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_valid", {31'h0, bus.out_valid}, {31'h0, e.v});
                check("out_wb", bus.out_wb, e.wb);
                check("out_memory", bus.out_memory, e.memv);
                check("rd_out", {27'h0, bus.rd_out}, {27'h0, e.rd});
                check("is_write_reg_out", {31'h0, bus.is_write_reg_out}, {31'h0, e.wr});
                check("misaligned", {31'h0, bus.misaligned}, {31'h0, e.mis});
            end
        end
    end

    // One stage cycle: drive, predict from the byte model, clock, enqueue the prediction.
    task automatic op(input logic v, input logic st, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic r, input logic [1:0] sz, input logic u,
                      input logic [4:0] rd, input logic wr, input logic chk, input logic [31:0] lit);
        int          n;
        int          ba;
        logic        acc;
        logic        m;
        logic        ld;
        logic [31:0] val;
        bus.in_valid        = v;
        bus.stall           = st;
        bus.out_alu         = a;
        bus.rdata2          = d;
        bus.is_write_mem    = w;
        bus.is_read_mem     = r;
        bus.mem_size        = sz;
        bus.is_unsigned     = u;
        bus.rd_in           = rd;
        bus.is_write_reg_in = wr;

        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ba = int'(a % 128);
        if (st) begin
            // outputs hold, memory untouched
        end else if (!v) begin
            held = '{1'b0, 32'h0, 32'h0, rd, 1'b0, 1'b0};
        end else begin
            acc = w | r;
            m   = acc && (ba % n != 0);
            ld  = r && !w;
            val = 32'h0;
            if (ld && !m) begin
                for (int i = 0; i < n; i++) val = val | (32'(bmem[ba+i]) << (8 * i));
                if (!u && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            end
            if (w && !m) begin
                for (int i = 0; i < n; i++) bmem[ba+i] = 8'(d >> (8 * i));
            end
            held = '{1'b1, ld ? val : a, ld ? val : 32'h0, rd, wr && !m, m};
        end

        @(posedge clk);
        exp_q.push_back(held);
        #1;
        if (chk) check("load_literal", bus.out_memory, lit);
    endtask

    initial begin
        int guard;
        bus.in_valid = 0; bus.stall = 0; bus.out_alu = 0; bus.rdata2 = 0;
        bus.is_write_mem = 0; bus.is_read_mem = 0; bus.mem_size = 0; bus.is_unsigned = 0;
        bus.rd_in = 0; bus.is_write_reg_in = 0;
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("reset_out_wb", bus.out_wb, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        op(1,0,32'h08,32'hDEADBEEF,1,0,2'd2,0,5'd1,0,0,0);
        op(1,0,32'h08,32'h0,0,1,2'd2,0,5'd2,1,1,32'hDEADBEEF);
        op(1,0,32'h04,32'h80F07F01,1,0,2'd2,0,5'd0,0,0,0);
        op(1,0,32'h07,32'h0,0,1,2'd0,0,5'd3,1,1,32'hFFFFFF80);
        op(1,0,32'h07,32'h0,0,1,2'd0,1,5'd4,1,1,32'h00000080);
        op(1,0,32'h06,32'h0,0,1,2'd1,0,5'd5,1,1,32'hFFFF80F0);
        op(1,0,32'h04,32'h0,0,1,2'd1,1,5'd6,1,1,32'h00007F01);
        op(1,0,32'h00,32'h11223344,1,0,2'd2,0,5'd0,0,0,0);
        op(1,0,32'h02,32'h000000AB,1,0,2'd0,0,5'd0,0,0,0);
        op(1,0,32'h00,32'h0,0,1,2'd2,0,5'd7,1,1,32'h11AB3344);
        op(1,0,32'h06,32'h55555555,1,0,2'd2,0,5'd8,1,0,0);
        op(1,0,32'h04,32'h0,0,1,2'd2,0,5'd9,1,1,32'h80F07F01);
        op(1,0,32'h80,32'hCAFEF00D,1,1,2'd3,0,5'd0,0,0,0);
        op(1,0,32'h00,32'h0,0,1,2'd2,0,5'd10,1,1,32'hCAFEF00D);
        for (int i = 0; i < 3; i++) op(1,1,32'h04,32'h12345678,1,0,2'd2,0,5'd11,1,0,0);
        op(1,0,32'h04,32'h0,0,1,2'd2,0,5'd12,1,1,32'h80F07F01);
        op(0,0,32'h04,32'h99999999,1,0,2'd2,0,5'd13,1,0,0);
        op(1,0,32'h04,32'h0,0,1,2'd2,0,5'd14,1,1,32'h80F07F01);
        op(1,0,32'h10,32'h77777777,1,0,2'd2,0,5'd15,1,0,0);

        // Asynchronous reset mid-cycle while a store is presented.
        #4;
        bus.in_valid = 1; bus.stall = 0; bus.out_alu = 32'h10; bus.rdata2 = 32'hA5A5A5A5;
        bus.is_write_mem = 1; bus.is_read_mem = 0; bus.mem_size = 2'd2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_wb", bus.out_wb, 32'h0);
        check("rst_out_memory", bus.out_memory, 32'h0);
        check("rst_rd_out", {27'h0, bus.rd_out}, 32'h0);
        check("rst_is_write_reg_out", {31'h0, bus.is_write_reg_out}, 32'h0);
        check("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        op(1,0,32'h10,32'h0,0,1,2'd2,0,5'd16,1,1,32'h00000000);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd0) ? 32'hFFFF_FFFF :
                                                    (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            if ($urandom_range(0, 1) == 0) a = a & 32'h0000_007F;
            op($urandom_range(0, 6) != 0, $urandom_range(0, 4) == 0, a, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cpu_mem_stage.md
# cpu_mem_stage

Parametrised memory stage (pipeline step 4) of the CPU, between the execute stage (ALU result, store data) and write-back. It holds a byte-addressable data memory of DEPTH 32-bit words and supports byte, halfword and word loads and stores with sign or zero extension. It also flags misaligned accesses and registers its results into the MEM/WB pipeline register. A hazard-unit stall freezes the stage.

## Interface
- WIDTH, 32: datapath width; only 32 is supported.
- DEPTH, 32: number of 32-bit memory words; power of two, ≥ 2.
- Derived: IDX_W = $clog2(DEPTH). The word index is addr[IDX_W+1:2].

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the instruction in this stage is real; 0 means a bubble.
- stall  input  1  hazard-unit hold.
- out_alu  input  WIDTH  ALU result; used as the byte address and as the write-back pass-through.
- rdata2  input  WIDTH  store data from the register file.
- is_write_mem  input  1  store.
- is_read_mem  input  1  load.
- mem_size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- is_unsigned  input  1  loads zero-extend when 1 and sign-extend when 0.
- rd_in  input  5  destination register.
- is_write_reg_in  input  1  register write enable.
- out_valid  output  1  MEM/WB register holds a real instruction.
- out_wb  output  WIDTH  write-back value: load data for loads, otherwise out_alu.
- out_memory  output  WIDTH  extended load data; 0 for non-loads.
- rd_out  output  5  registered rd_in.
- is_write_reg_out  output  1  registered register write enable, gated as described under Operation.
- misaligned  output  1  registered misaligned-access flag.

## Operation
- **Active access:** an access is active when in_valid=1 and stall=0.
- **Store priority:** if is_write_mem and is_read_mem are both set, the access is a store and the load is suppressed.
- **Address mapping:**
  - Byte lane is addr[1:0].
  - Word index is addr[IDX_W+1:2].
  - Address bits above IDX_W+1 are ignored, so addresses wrap modulo 4·DEPTH.
- **Alignment:**
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - A misaligned active access writes no memory, gives a load result of 0, and forces is_write_reg_out=0.
- **Stores (little-endian byte lanes):**
  - Byte: rdata2[7:0] goes to lane addr[1:0].
  - Halfword: rdata2[15:0] goes to lanes addr[1]*2 and addr[1]*2+1.
  - Word: all four lanes are written.
  - Bytes outside the written lanes are unchanged.
- **Loads:**
  - The selected byte or halfword is right-aligned.
  - It is sign-extended when is_unsigned=0 and zero-extended when is_unsigned=1.
  - A word is returned unchanged.
  - The read is from memory contents before the current edge.
- **Bubble:** when in_valid=0 and stall=0:
  - No memory write occurs.
  - At the edge, out_valid=0 and is_write_reg_out=0.
  - out_wb, out_memory and misaligned are all 0.
- **Stall:** when stall=1:
  - No memory write occurs.
  - The MEM/WB register holds every output unchanged.
- **Reset:**
  - All memory words are set to 0.
  - out_valid, out_wb, out_memory, rd_out, is_write_reg_out and misaligned are all set to 0.
  - Reset asserted mid-operation aborts any store on that cycle.

## Timing
- **Latency:** one cycle. Inputs sampled at edge N appear on the outputs after edge N, until edge N+1.
- **Store commit:** stores commit at edge N.
- **Store-to-load:** a load of the same bytes sampled at edge N+1 returns the new data. There is no same-cycle forwarding.
- **Stall release:** outputs update at the first edge with stall=0.
- **Reset release:** reset deasserts asynchronously to the clock. The first functional edge is the first rising edge with rst=0.
- **Output logic:** all outputs come directly from flops, with no combinational path from inputs to outputs.

## Test plan
- **Reset:**
  - Stimulus: assert rst mid-run, with the memory previously written.
  - Required response: all outputs are 0 immediately, before any clock edge. After release, a word load from address 0x10 returns 0x00000000.
- **Word store/load:**
  - Stimulus: store word 0xDEADBEEF at address 0x08, then load a word from 0x08 on the next cycle.
  - Required response: out_memory = out_wb = 0xDEADBEEF and out_valid=1, both one cycle after the load is sampled.
- **Byte/halfword extension:**
  - Stimulus: store word 0x80F07F01 at 0x04, then perform four loads: signed byte at 0x07, unsigned byte at 0x07, signed halfword at 0x06, unsigned halfword at 0x04.
  - Required response: 0xFFFFFF80, 0x00000080, 0xFFFF80F0, 0x00007F01.
- **Partial store:**
  - Stimulus: start from word 0x11223344 at 0x00, then store byte 0xAB at 0x02.
  - Required response: a word load from 0x00 returns 0x11AB3344.
- **Misaligned and wrap:**
  - Misaligned stimulus: a word store to 0x06.
    - Required response: memory is unchanged, misaligned=1 and is_write_reg_out=0.
  - Wrap stimulus (DEPTH=32): store to 0x80, then load from 0x00.
    - Required response: the load returns the stored value.
- **Stall and bubble:**
  - Stall stimulus: hold stall=1 for 3 cycles while presenting a store.
    - Required response: no memory change and outputs frozen throughout the stall.
  - Bubble stimulus: in_valid=0 with is_write_mem=1.
    - Required response: no write and out_valid=0.
